// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder and the memory-access stage.
// Holds the request-length encodings, the responder state enum and the bus widths.
// Also provides the alignment/length legality helper used by the error check.
package dmem_responder_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int LEN_W  = 2;
    localparam int CNT_W  = 4;

    // req_len encodings; the memory-access stage uses these same values.
    localparam logic [LEN_W-1:0] LEN_BYTE = 2'b00;
    localparam logic [LEN_W-1:0] LEN_HALF = 2'b01;
    localparam logic [LEN_W-1:0] LEN_WORD = 2'b10;
    localparam logic [LEN_W-1:0] LEN_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // 1 when the length is reserved or the address is not naturally aligned for it.
    function automatic logic len_addr_bad(input logic [LEN_W-1:0] len, input logic [1:0] addr_lo);
        logic bad;
        case (len)
            LEN_BYTE: bad = 1'b0;
            LEN_HALF: bad = addr_lo[0];
            LEN_WORD: bad = |addr_lo;
            default:  bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane alignment for the data memory: store merge, byte strobes and load extraction.
// Latency: purely combinational. Backpressure: none (no handshake of its own).
// Ports: i_len/i_addr_lo select the lanes, i_wdata is right-justified store data,
//        i_old_word is the current array word; o_merged, o_strb, o_rdata (zero-extended).
module dmem_lane_align
    import dmem_responder_pkg::*;
(
    input  logic [LEN_W-1:0]  i_len,
    input  logic [1:0]        i_addr_lo,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [DATA_W-1:0] i_old_word,
    output logic [DATA_W-1:0] o_merged,
    output logic [3:0]        o_strb,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] w_lanes;
    logic [DATA_W-1:0] w_shifted;

    always_comb begin
        o_strb    = 4'b0000;
        w_lanes   = i_wdata;
        w_shifted = i_old_word;
        o_rdata   = '0;
        case (i_len)
            LEN_BYTE: begin
                o_strb    = 4'b0001 << i_addr_lo;
                // Replicate the byte so the strobe alone picks the destination lane.
                w_lanes   = {4{i_wdata[7:0]}};
                w_shifted = i_old_word >> {i_addr_lo, 3'b000};
                o_rdata   = {24'd0, w_shifted[7:0]};
            end
            LEN_HALF: begin
                o_strb    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                w_lanes   = {2{i_wdata[15:0]}};
                w_shifted = i_old_word >> {i_addr_lo[1], 4'b0000};
                o_rdata   = {16'd0, w_shifted[15:0]};
            end
            LEN_WORD: begin
                o_strb  = 4'b1111;
                o_rdata = i_old_word;
            end
            default: begin
                // Reserved length: no lanes selected, nothing returned.
                o_strb = 4'b0000;
            end
        endcase

        o_merged = i_old_word;
        for (int i = 0; i < 4; i++) begin
            if (o_strb[i]) begin
                o_merged[8*i +: 8] = w_lanes[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: target of the pipeline load/store port, holds the data array.
// Latency: response valid WAIT_CYCLES+1 edges after the accept edge; one request in flight.
// Backpressure: req_ready low outside IDLE; response held stable until resp_ready.
// Ports: clk, rst (async active-low); req_valid/req_ready/req_we/req_len/req_addr/req_wdata;
//        resp_valid/resp_ready/resp_rdata/resp_err.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [LEN_W-1:0]  req_len,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
);

    localparam int                IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [ADDR_W-1:0] DEPTH_L = ADDR_W'(DEPTH_WORDS);

    state_e             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_we;
    logic [LEN_W-1:0]   r_len;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic               r_req_ready;
    logic               r_resp_valid;
    logic [DATA_W-1:0]  r_resp_rdata;
    logic               r_resp_err;
    logic [DATA_W-1:0]  r_mem [DEPTH_WORDS];

    logic [ADDR_W-1:0]  w_offset;
    logic [IDX_W-1:0]   w_idx;
    logic               w_err;
    logic               w_access;
    logic               w_mem_we;
    logic [DATA_W-1:0]  w_old;
    logic [DATA_W-1:0]  w_merged;
    logic [DATA_W-1:0]  w_load;
    logic [3:0]         w_strb;

    // Everything below works on the latched request, never on the live request bus.
    assign w_offset = r_addr - ADDR_BASE;
    assign w_idx    = w_offset[IDX_W+1:2];
    assign w_err    = len_addr_bad(r_len, r_addr[1:0])
                    || (r_addr < ADDR_BASE)
                    || ((w_offset >> 2) >= DEPTH_L);
    assign w_access = (r_state == ST_BUSY) && (r_cnt == '0);
    // Reset forces IDLE, so a store cut off by reset never reaches the array.
    assign w_mem_we = w_access && r_we && !w_err && (|w_strb);
    assign w_old    = r_mem[w_idx];

    dmem_lane_align u_lane_align (
        .i_len      (r_len),
        .i_addr_lo  (r_addr[1:0]),
        .i_wdata    (r_wdata),
        .i_old_word (w_old),
        .o_merged   (w_merged),
        .o_strb     (w_strb),
        .o_rdata    (w_load)
    );

    // Array contents survive reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_idx] <= w_merged;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_we         <= 1'b0;
            r_len        <= LEN_BYTE;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_req_ready  <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Ready rises on the first edge after reset release.
                    r_req_ready <= 1'b1;
                    if (r_req_ready && req_valid) begin
                        r_we        <= req_we;
                        r_len       <= req_len;
                        r_addr      <= req_addr;
                        r_wdata     <= req_wdata;
                        r_cnt       <= CNT_W'(WAIT_CYCLES);
                        r_req_ready <= 1'b0;
                        r_state     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= w_err;
                        r_resp_rdata <= (r_we || w_err) ? '0 : w_load;
                        r_state      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_resp_rdata <= '0;
                        r_resp_err   <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_state      <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    localparam int          DEPTH = 64;
    localparam int          WAITC = 1;
    localparam logic [31:0] BASE  = 32'h0000_0100;
    localparam int          NV    = 29;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_len = 2'b00;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: byte-addressed little-endian memory image.
    logic [7:0] mb [DEPTH*4];

    typedef struct {
        logic        we;
        logic [1:0]  len;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t tbl [NV];

    always #5 clk = ~clk;

    dmem_responder #(
        .DEPTH_WORDS (DEPTH),
        .WAIT_CYCLES (WAITC),
        .ADDR_BASE   (BASE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_len    (req_len),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic m_err(input logic [1:0] len, input logic [31:0] addr);
        longint off;
        if (len == 2'b11) return 1'b1;
        if ((addr % (32'd1 << len)) != 0) return 1'b1;
        off = longint'(addr) - longint'(BASE);
        if (off < 0) return 1'b1;
        if ((off / 4) >= DEPTH) return 1'b1;
        return 1'b0;
    endfunction

    task automatic m_access(input logic we, input logic [1:0] len, input logic [31:0] addr,
                            input logic [31:0] wdata, output logic [31:0] rd, output logic er);
        int off;
        int nb;
        rd = '0;
        er = m_err(len, addr);
        if (er) return;
        off = int'(addr - BASE);
        nb  = 1 << len;
        for (int i = 0; i < nb; i++) begin
            if (we) mb[off+i] = wdata[8*i +: 8];
            else    rd[8*i +: 8] = mb[off+i];
        end
    endtask

    // One complete request/response exchange with checks on every phase.
    task automatic xfer(input string nm, input logic we, input logic [1:0] len, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_er,
                        input int hold);
        int n;
        int lat;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (req_ready !== 1'b1) begin
            chk({nm, "_ready_timeout"}, 32'(req_ready), 32'd1);
            return;
        end
        req_valid = 1'b1;
        req_we    = we;
        req_len   = len;
        req_addr  = addr;
        req_wdata = wdata;
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_len   = 2'($urandom);
        chk({nm, "_ready_drop"}, 32'(req_ready), 32'd0);
        lat = 0;
        while (resp_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, "_latency"}, lat, WAITC + 1);
        if (resp_valid !== 1'b1) return;
        chk({nm, "_rdata"}, resp_rdata, exp_rd);
        chk({nm, "_err"}, 32'(resp_err), 32'(exp_er));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({nm, "_hold_valid"}, 32'(resp_valid), 32'd1);
            chk({nm, "_hold_rdata"}, resp_rdata, exp_rd);
            chk({nm, "_hold_err"}, 32'(resp_err), 32'(exp_er));
            chk({nm, "_hold_ready"}, 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk({nm, "_clr_valid"}, 32'(resp_valid), 32'd0);
        chk({nm, "_clr_rdata"}, resp_rdata, 32'd0);
        chk({nm, "_clr_err"}, 32'(resp_err), 32'd0);
        chk({nm, "_clr_ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, tests run %0d, required completion", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] wd;
        logic [31:0] e1;
        logic [31:0] e2;
        logic [31:0] a;
        logic        er;
        logic        we;
        logic [1:0]  ln;
        int          n;
        int          off;
        int          r;
        int          hold;

        tbl[0]  = '{1'b1, LEN_WORD, BASE + 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0};
        tbl[1]  = '{1'b0, LEN_WORD, BASE + 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0};
        tbl[2]  = '{1'b1, LEN_WORD, BASE + 32'h10, 32'h1122_3344, 32'h0, 1'b0};
        tbl[3]  = '{1'b1, LEN_BYTE, BASE + 32'h13, 32'h1234_56AA, 32'h0, 1'b0};
        tbl[4]  = '{1'b0, LEN_WORD, BASE + 32'h10, 32'h0, 32'hAA22_3344, 1'b0};
        tbl[5]  = '{1'b0, LEN_BYTE, BASE + 32'h12, 32'h0, 32'h0000_0022, 1'b0};
        tbl[6]  = '{1'b0, LEN_HALF, BASE + 32'h11, 32'h0, 32'h0, 1'b1};
        tbl[7]  = '{1'b0, LEN_WORD, BASE + 32'h12, 32'h0, 32'h0, 1'b1};
        tbl[8]  = '{1'b0, LEN_RSVD, BASE + 32'h10, 32'h0, 32'h0, 1'b1};
        tbl[9]  = '{1'b1, LEN_WORD, BASE + 32'h11, 32'hFFFF_FFFF, 32'h0, 1'b1};
        tbl[10] = '{1'b1, LEN_RSVD, BASE + 32'h10, 32'hFFFF_FFFF, 32'h0, 1'b1};
        tbl[11] = '{1'b1, LEN_HALF, BASE + 32'h13, 32'hFFFF_FFFF, 32'h0, 1'b1};
        tbl[12] = '{1'b0, LEN_WORD, BASE + 32'h10, 32'h0, 32'hAA22_3344, 1'b0};
        tbl[13] = '{1'b1, LEN_HALF, BASE + 32'h12, 32'h9999_5566, 32'h0, 1'b0};
        tbl[14] = '{1'b0, LEN_WORD, BASE + 32'h10, 32'h0, 32'h5566_3344, 1'b0};
        tbl[15] = '{1'b0, LEN_HALF, BASE + 32'h12, 32'h0, 32'h0000_5566, 1'b0};
        tbl[16] = '{1'b0, LEN_HALF, BASE + 32'h10, 32'h0, 32'h0000_3344, 1'b0};
        tbl[17] = '{1'b0, LEN_BYTE, BASE + 32'h11, 32'h0, 32'h0000_0033, 1'b0};
        tbl[18] = '{1'b1, LEN_BYTE, BASE + 32'h10, 32'h8765_4377, 32'h0, 1'b0};
        tbl[19] = '{1'b0, LEN_WORD, BASE + 32'h10, 32'h0, 32'h5566_3377, 1'b0};
        tbl[20] = '{1'b1, LEN_WORD, BASE + 32'h00, 32'h0102_0304, 32'h0, 1'b0};
        tbl[21] = '{1'b1, LEN_WORD, BASE + 32'(DEPTH*4), 32'hFFFF_FFFF, 32'h0, 1'b1};
        tbl[22] = '{1'b0, LEN_WORD, BASE + 32'(DEPTH*4), 32'h0, 32'h0, 1'b1};
        tbl[23] = '{1'b0, LEN_WORD, BASE + 32'h00, 32'h0, 32'h0102_0304, 1'b0};
        tbl[24] = '{1'b1, LEN_WORD, BASE + 32'(DEPTH*4 - 4), 32'hCAFE_F00D, 32'h0, 1'b0};
        tbl[25] = '{1'b0, LEN_WORD, BASE + 32'(DEPTH*4 - 4), 32'h0, 32'hCAFE_F00D, 1'b0};
        tbl[26] = '{1'b0, LEN_WORD, BASE - 32'h4, 32'h0, 32'h0, 1'b1};
        tbl[27] = '{1'b1, LEN_BYTE, BASE - 32'h1, 32'h0000_00EE, 32'h0, 1'b1};
        tbl[28] = '{1'b0, LEN_BYTE, BASE + 32'h13, 32'h0, 32'h0000_0055, 1'b0};

        // Reset state.
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        rst = 1'b1;
        #1;
        chk("rel_ready_before_edge", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("rel_ready_after_edge", 32'(req_ready), 32'd1);

        // Fill the whole array with known data.
        for (int i = 0; i < DEPTH; i++) begin
            wd = $urandom;
            a  = BASE + 32'(4*i);
            m_access(1'b1, LEN_WORD, a, wd, rd, er);
            xfer("init", 1'b1, LEN_WORD, a, wd, 32'h0, 1'b0, 0);
        end

        // Reset while a store is in BUSY: it must be dropped without writing.
        a = BASE + 32'h20;
        m_access(1'b0, LEN_WORD, a, 32'h0, e1, er);
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        req_valid = 1'b1; req_we = 1'b1; req_len = LEN_WORD; req_addr = a; req_wdata = ~e1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rstbusy_accepted", 32'(req_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("rstbusy_ready_in_rst", 32'(req_ready), 32'd0);
        chk("rstbusy_valid_in_rst", 32'(resp_valid), 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("rstbusy_valid_held_rst", 32'(resp_valid), 32'd0);
        rst = 1'b1;
        #1;
        chk("rstbusy_ready_at_release", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("rstbusy_ready_after_edge", 32'(req_ready), 32'd1);
        repeat (4) begin
            @(negedge clk);
            chk("rstbusy_no_resp", 32'(resp_valid), 32'd0);
        end
        xfer("rstbusy_readback", 1'b0, LEN_WORD, a, 32'h0, e1, 1'b0, 0);

        // Directed vectors.
        for (int i = 0; i < NV; i++) begin
            m_access(tbl[i].we, tbl[i].len, tbl[i].addr, tbl[i].wdata, rd, er);
            xfer($sformatf("tbl%0d", i), tbl[i].we, tbl[i].len, tbl[i].addr, tbl[i].wdata,
                 tbl[i].exp_rdata, tbl[i].exp_err, 0);
        end

        // Response stalled 5 cycles with a new request waiting behind it.
        m_access(1'b0, LEN_WORD, BASE + 32'h18, 32'h0, e1, er);
        m_access(1'b0, LEN_BYTE, BASE + 32'h19, 32'h0, e2, er);
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        req_valid = 1'b1; req_we = 1'b0; req_len = LEN_WORD; req_addr = BASE + 32'h18;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (resp_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        chk("stall_lat1", n, WAITC + 1);
        chk("stall_rdata1", resp_rdata, e1);
        req_valid = 1'b1; req_we = 1'b0; req_len = LEN_BYTE; req_addr = BASE + 32'h19;
        repeat (5) begin
            @(negedge clk);
            chk("stall_valid", 32'(resp_valid), 32'd1);
            chk("stall_rdata", resp_rdata, e1);
            chk("stall_err", 32'(resp_err), 32'd0);
            chk("stall_req_ready", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("stall_release_valid", 32'(resp_valid), 32'd0);
        chk("stall_release_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("stall_second_accepted", 32'(req_ready), 32'd0);
        n = 0;
        while (resp_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        chk("stall_lat2", n, WAITC + 1);
        chk("stall_rdata2", resp_rdata, e2);
        chk("stall_err2", 32'(resp_err), 32'd0);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;

        // Randomized traffic against the byte-image model.
        for (int k = 0; k < 250; k++) begin
            we  = 1'($urandom_range(0, 1));
            r   = $urandom_range(0, 9);
            ln  = (r < 3) ? LEN_BYTE : (r < 6) ? LEN_HALF : (r < 9) ? LEN_WORD : LEN_RSVD;
            off = int'($urandom_range(0, DEPTH*4 + 15)) - 8;
            a   = BASE + 32'(off);
            if (ln != LEN_RSVD && $urandom_range(0, 1) == 1) begin
                a = a & ~(32'((1 << ln) - 1));
            end
            wd   = $urandom;
            hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            m_access(we, ln, a, wd, rd, er);
            xfer($sformatf("rnd%0d", k), we, ln, a, wd, rd, er, hold);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
